// File: rtl/pwm_compare_pkg.sv
// Shared definitions for the PWM comparator: count bus width and controller states.
package pwm_compare_pkg;

  localparam int unsigned COUNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PENDING = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_compare_shadow_reg.sv
// Shadow duty register with valid/ready accept logic; saturates requests above 2**W.
module pwm_compare_shadow_reg #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic         cfg_ready,
  input  logic [W:0]   cfg_duty,
  output logic         accept_c,
  output logic [W:0]   duty_shadow
);

  localparam logic [W:0] DUTY_FULL = {1'b1, {W{1'b0}}};

  logic [W:0] duty_sat_c;

  assign accept_c   = cfg_valid && cfg_ready;
  assign duty_sat_c = (cfg_duty > DUTY_FULL) ? DUTY_FULL : cfg_duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow <= '0;
    end else if (accept_c) begin
      duty_shadow <= duty_sat_c;
    end
  end

endmodule

// File: rtl/pwm_compare.sv
// PWM comparator on the free-running up_counter bus; duty updates take effect only at the MAX->0 wrap.
module pwm_compare
  import pwm_compare_pkg::*;
#(
  parameter int unsigned W   = COUNT_W,
  parameter bit          POL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] count,
  input  logic         cfg_valid,
  input  logic [W:0]   cfg_duty,
  output logic         cfg_ready,
  output logic         pwm,
  output logic         period_start
);

  localparam logic [W-1:0] MAX = '1;

  pwm_state_t state;
  logic [W-1:0] cnt_q;
  logic [W:0]   duty_active;
  logic [W:0]   duty_shadow;
  logic [W:0]   duty_eff_c;
  logic         accept_c;
  logic         wrap_c;
  logic         pwm_on_c;

  pwm_compare_shadow_reg #(.W(W)) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_duty    (cfg_duty),
    .accept_c    (accept_c),
    .duty_shadow (duty_shadow)
  );

  // Only a clean MAX->0 step counts as a period boundary; any other jump is just a new count.
  assign wrap_c     = (cnt_q == MAX) && (count == '0);
  assign duty_eff_c = ((state == ST_PENDING) && wrap_c) ? duty_shadow : duty_active;
  assign pwm_on_c   = ({1'b0, count} < duty_eff_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cfg_ready    <= 1'b1;
      duty_active  <= '0;
      cnt_q        <= '0;
      pwm          <= ~POL;
      period_start <= 1'b0;
    end else begin
      cnt_q        <= count;
      period_start <= wrap_c;
      pwm          <= (state == ST_IDLE) ? ~POL : (pwm_on_c ? POL : ~POL);
      // An accept coinciding with a wrap in RUN leaves duty_active alone until the next wrap.
      case (state)
        ST_IDLE, ST_RUN: begin
          if (accept_c) begin
            state     <= ST_PENDING;
            cfg_ready <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (wrap_c) begin
            state       <= ST_RUN;
            duty_active <= duty_shadow;
            cfg_ready   <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare driven by a free-running 6-bit count with optional jumps.
module tb_pwm_compare;
  import pwm_compare_pkg::*;

  localparam int unsigned W = COUNT_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         crst;
  logic         jump_en;
  logic [W-1:0] jump_val;
  logic [W-1:0] count;
  logic         cfg_valid;
  logic [W:0]   cfg_duty;
  logic         cfg_ready;
  logic         pwm;
  logic         period_start;

  int total = 0;
  int bad   = 0;

  pwm_compare #(.W(W), .POL(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .count        (count),
    .cfg_valid    (cfg_valid),
    .cfg_duty     (cfg_duty),
    .cfg_ready    (cfg_ready),
    .pwm          (pwm),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // Upstream counter stand-in: free-running, with a forced-jump hook.
  always @(posedge clk) begin
    if (crst)         count <= '0;
    else if (jump_en) count <= jump_val;
    else              count <= count + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_wrap(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_wrap"}, 32'(seen), 32'd1);
  endtask

  // Called on the period_start sample; sample i is pwm for count i.
  task automatic measure(input string tag, input int exp_hi);
    int   hi;
    int   late;
    logic low_seen;
    hi = 0; late = 0; low_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) cfg_valid = 1'b0;
      if (pwm === 1'b1) begin
        hi++;
        if (low_seen) late++;
      end else begin
        low_seen = 1'b1;
      end
    end
    chk({tag, "_hi"}, 32'(hi), 32'(exp_hi));
    chk({tag, "_contig"}, 32'(late), 32'd0);
  endtask

  task automatic offer(input int duty);
    cfg_valid = 1'b1;
    cfg_duty  = (W+1)'(duty);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic apply(input string tag, input int duty, input int exp_hi);
    repeat (5) @(negedge clk);
    offer(duty);
    chk({tag, "_rdy"}, 32'(cfg_ready), 32'd0);
    wait_wrap(tag);
    measure(tag, exp_hi);
  endtask

  initial begin
    int ps;
    rst = 1'b1; crst = 1'b1; jump_en = 1'b0; jump_val = '0;
    cfg_valid = 1'b0; cfg_duty = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_rdy", 32'(cfg_ready), 32'd1);
    chk("rst_ps", 32'(period_start), 32'd0);
    rst = 1'b0; crst = 1'b0;

    ps = 0;
    repeat (60) begin
      @(negedge clk);
      if (period_start === 1'b1) ps++;
    end
    chk("no_early_ps", 32'(ps), 32'd0);
    wait_wrap("first");
    measure("idle", 0);

    repeat (10) @(negedge clk);
    offer(16);
    chk("rdy_drop", 32'(cfg_ready), 32'd0);
    wait_wrap("d16");
    chk("rdy_rise", 32'(cfg_ready), 32'd1);
    measure("d16", 16);

    apply("d0", 0, 0);
    apply("d64", 64, 64);
    apply("d100", 100, 64);
    apply("d63", 63, 63);

    repeat (5) @(negedge clk);
    offer(20);
    cfg_valid = 1'b1;
    cfg_duty  = 7'd40;
    repeat (3) @(negedge clk);
    chk("bp_rdy", 32'(cfg_ready), 32'd0);
    wait_wrap("bp");
    chk("bp_rise", 32'(cfg_ready), 32'd1);
    measure("bp20", 20);
    wait_wrap("bp40");
    measure("bp40", 40);

    apply("d32", 32, 32);
    cfg_valid = 1'b1;
    cfg_duty  = 7'd8;
    wait_wrap("sim");
    chk("sim_rdy", 32'(cfg_ready), 32'd0);
    measure("sim32", 32);
    wait_wrap("sim8");
    measure("sim8", 8);

    repeat (5) @(negedge clk);
    offer(48);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_pwm", 32'(pwm), 32'd0);
    chk("mrst_rdy", 32'(cfg_ready), 32'd1);
    wait_wrap("mrst");
    measure("mrst_idle", 0);

    repeat (5) @(negedge clk);
    jump_val = '0; jump_en = 1'b1;
    @(negedge clk);
    jump_val = 6'd63;
    @(negedge clk);
    jump_val = 6'd5;
    @(negedge clk);
    jump_en = 1'b0;
    ps = 0;
    repeat (20) begin
      @(negedge clk);
      if (period_start === 1'b1) ps++;
    end
    chk("jump_no_ps", 32'(ps), 32'd0);
    wait_wrap("post_jump");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
